pipe_ctrl: RTL

//  Pipeline sequencer for the 5-stage core: merges per-stage stall requests into stall[5:0] and turns

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_if.sv | 34 +++
 rtl/pipe_ctrl_wdog.sv | 32 +++
 rtl/pipe_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: stall masks, ERET code,
// sequencer state encoding and the stall priority helper.
package pipe_ctrl_pkg;

    localparam int          STALL_W    = 6;
    localparam logic [5:0]  STALL_NONE = 6'b000000;
    localparam logic [5:0]  STALL_ID   = 6'b000111;
    localparam logic [5:0]  STALL_EX   = 6'b001111;
    localparam logic [5:0]  STALL_MEM  = 6'b011111;
    localparam logic [5:0]  STALL_ALL  = 6'b111111;
    localparam logic [31:0] EXC_ERET   = 32'h0000000e;

    typedef enum logic [1:0] {
        PC_RUN     = 2'd0,
        PC_FREEZE  = 2'd1,
        PC_FLUSH   = 2'd2,
        PC_RECOVER = 2'd3
    } pc_state_e;

    // Later stages win: a stalled stage must also hold everything upstream of it.
    function automatic logic [5:0] stall_mux(input logic id, input logic ex, input logic mem);
        if (mem)     return STALL_MEM;
        else if (ex) return STALL_EX;
        else if (id) return STALL_ID;
        else         return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush/redirect bundle between the pipeline stages (master) and pipe_ctrl (slave).
// Perf counter signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        exc_valid;
    logic [31:0] exc_type;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        wdog_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, exc_valid, exc_type, cp0_epc,
        input  stall, flush, new_pc, wdog_timeout
`ifdef PIPE_CTRL_PERF_EN
        , input perf_stall_cyc, perf_flush_cnt
`endif
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, exc_valid, exc_type, cp0_epc,
        output stall, flush, new_pc, wdog_timeout
`ifdef PIPE_CTRL_PERF_EN
        , output perf_stall_cyc, perf_flush_cnt
`endif
    );
endinterface

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog: saturating counter of consecutive stalled RUN cycles; fire is high
// while the count sits at STALL_TIMEOUT. clr takes priority over count_en.
module pipe_ctrl_wdog #(
    parameter int STALL_TIMEOUT = 1024,
    parameter int WDOG_W        = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en_i,
    input  logic clr_i,
    output logic fire_o
);
    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(STALL_TIMEOUT);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (count_en_i && (cnt_q != LIMIT))
            cnt_d = cnt_q + WDOG_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign fire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall priority mux, exception/ERET/watchdog redirect FSM
// (RUN->FREEZE->FLUSH->RECOVER). Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'hbfc00380,
    parameter int          STALL_TIMEOUT = 1024,
    parameter int          WDOG_W        = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave ctrl_if
);
    pc_state_e   state_q, state_d;
    logic [31:0] target_q, target_d;
    logic        flush_q, flush_d;
    logic [5:0]  stall_c;
    logic        wdog_pulse_c;
    logic        any_req;
    logic        wd_en, wd_clr, wd_fire;

    assign any_req = ctrl_if.stallreq_id | ctrl_if.stallreq_ex | ctrl_if.stallreq_mem;

    pipe_ctrl_wdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT),
        .WDOG_W        (WDOG_W)
    ) u_wdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_en_i (wd_en),
        .clr_i      (wd_clr),
        .fire_o     (wd_fire)
    );

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        stall_c      = STALL_NONE;
        wdog_pulse_c = 1'b0;
        wd_en        = 1'b0;
        wd_clr       = 1'b1;
        case (state_q)
            PC_RUN: begin
                stall_c = stall_mux(ctrl_if.stallreq_id, ctrl_if.stallreq_ex, ctrl_if.stallreq_mem);
                wd_en   = any_req;
                wd_clr  = ~any_req;
                // A committed exception outranks a simultaneous watchdog fire.
                if (ctrl_if.exc_valid) begin
                    stall_c  = STALL_ALL;
                    target_d = (ctrl_if.exc_type == EXC_ERET) ? ctrl_if.cp0_epc : EXC_VECTOR;
                    state_d  = PC_FREEZE;
                    wd_clr   = 1'b1;
                end else if (wd_fire) begin
                    target_d     = EXC_VECTOR;
                    wdog_pulse_c = 1'b1;
                    state_d      = PC_FREEZE;
                    wd_clr       = 1'b1;
                end
            end
            PC_FREEZE: begin
                stall_c = STALL_ALL;
                state_d = PC_FLUSH;
            end
            PC_FLUSH:   state_d = PC_RECOVER;
            PC_RECOVER: state_d = PC_RUN;
            default:    state_d = PC_RUN;
        endcase
    end

    assign flush_d = (state_d == PC_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PC_RUN;
            target_q <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            flush_q  <= flush_d;
        end
    end

    assign ctrl_if.stall        = stall_c;
    assign ctrl_if.flush        = flush_q;
    assign ctrl_if.new_pc       = target_q;
    assign ctrl_if.wdog_timeout = wdog_pulse_c;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // FREEZE always leads into FLUSH, so counting FREEZE cycles counts FLUSH entries.
    always_comb begin
        perf_stall_d = perf_stall_q + ((stall_c != STALL_NONE) ? 32'd1 : 32'd0);
        perf_flush_d = perf_flush_q + ((state_q == PC_FREEZE) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign ctrl_if.perf_stall_cyc = perf_stall_q;
    assign ctrl_if.perf_flush_cnt = perf_flush_q;
`endif

endmodule
